// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, instruction field positions, fetch FSM encoding.
package cpu_pkg;

    // Opcode values carried in instr[15:12]
    localparam logic [3:0] OP_TYPEA = 4'b1111;
    localparam logic [3:0] OP_ANDI  = 4'b1000;
    localparam logic [3:0] OP_ORI   = 4'b1001;
    localparam logic [3:0] OP_LBU   = 4'b1010;
    localparam logic [3:0] OP_SB    = 4'b1011;
    localparam logic [3:0] OP_LB    = 4'b1100;
    localparam logic [3:0] OP_SW    = 4'b1101;
    localparam logic [3:0] OP_BGT   = 4'b0100;
    localparam logic [3:0] OP_BLT   = 4'b0101;
    localparam logic [3:0] OP_BEQ   = 4'b0110;
    localparam logic [3:0] OP_JMP   = 4'b0001;
    localparam logic [3:0] OP_HALT  = 4'b0000;

    // Instruction field bit positions (16-bit instruction)
    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned RD_MSB  = 11;
    localparam int unsigned RD_LSB  = 8;
    localparam int unsigned RS_MSB  = 7;
    localparam int unsigned RS_LSB  = 4;
    localparam int unsigned FN_MSB  = 3;
    localparam int unsigned FN_LSB  = 0;

    // Fetch FSM states
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry instruction/pc buffer that parks a returned word while the slot is stalled.
module fetch_hold_buf #(
    parameter int unsigned PC_W    = 16,
    parameter int unsigned INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               unload,
    input  logic               clear,
    input  logic [PC_W-1:0]    load_pc,
    input  logic [INSTR_W-1:0] load_instr,
    output logic               valid,
    output logic [PC_W-1:0]    buf_pc,
    output logic [INSTR_W-1:0] buf_instr
);

    // Occupancy flag: clear/unload win over load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
        end else if (clear || unload) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end
    end

    // Payload captured on load only
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_pc    <= '0;
            buf_instr <= '0;
        end else if (load) begin
            buf_pc    <= load_pc;
            buf_instr <= load_instr;
        end
    end

endmodule

// File: rtl/fetch_decode.sv
// Instruction fetch and field split: one outstanding imem request, a presented slot,
// a one-entry hold buffer, redirect flush and stall handling.
// Optional FD_STALL_CNT_EN adds a saturating stall_cnt output.
module fetch_decode
    import cpu_pkg::*;
#(
    parameter int unsigned     PC_W     = 16,
    parameter int unsigned     INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               if_valid,
    output logic [PC_W-1:0]    if_pc,
    output logic [INSTR_W-1:0] if_instr,
    output logic [3:0]         if_opcode,
    output logic [3:0]         if_rd,
    output logic [3:0]         if_rs,
    output logic [3:0]         if_fn
`ifdef FD_STALL_CNT_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    fetch_state_e        state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [PC_W-1:0]     fetch_pc_q, fetch_pc_d;
    logic                drop_q, drop_d;
    logic                valid_q, valid_d;
    logic [PC_W-1:0]     if_pc_q, if_pc_d;
    logic [INSTR_W-1:0]  if_instr_q, if_instr_d;

    logic                buf_load, buf_unload, buf_clear;
    logic                buf_valid;
    logic [PC_W-1:0]     buf_pc;
    logic [INSTR_W-1:0]  buf_instr;

    logic                accept;
    logic                consume;

    assign accept  = (state_q == S_REQ) && imem_ready;
    assign consume = valid_q && !stall;

    // Hold buffer for a word that arrives while the slot is occupied
    fetch_hold_buf #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_hold (
        .clk        (clk),
        .reset      (reset),
        .load       (buf_load),
        .unload     (buf_unload),
        .clear      (buf_clear),
        .load_pc    (fetch_pc_q),
        .load_instr (imem_rdata),
        .valid      (buf_valid),
        .buf_pc     (buf_pc),
        .buf_instr  (buf_instr)
    );

    // State, pc and presented slot registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            fetch_pc_q <= '0;
            drop_q     <= 1'b0;
            valid_q    <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
            drop_q     <= drop_d;
            valid_q    <= valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
        end
    end

    // Next state: redirect first, then response/consume handling
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q;
        valid_d    = valid_q && !consume;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        buf_load   = 1'b0;
        buf_unload = 1'b0;
        buf_clear  = 1'b0;

        if (accept) begin
            fetch_pc_d = pc_q;
            pc_d       = pc_q + PC_W'(2);
        end

        if (redirect) begin
            pc_d      = redirect_pc;
            valid_d   = 1'b0;
            buf_clear = 1'b1;
            case (state_q)
                S_REQ: begin
                    if (imem_ready) begin
                        state_d = S_WAIT;
                        drop_d  = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state_d = S_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (imem_ready) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state_d = S_REQ;
                        if (drop_q) begin
                            drop_d = 1'b0;
                        end else if (!valid_q || consume) begin
                            valid_d    = 1'b1;
                            if_pc_d    = fetch_pc_q;
                            if_instr_d = imem_rdata;
                        end else begin
                            buf_load = 1'b1;
                            state_d  = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (consume && buf_valid) begin
                        valid_d    = 1'b1;
                        if_pc_d    = buf_pc;
                        if_instr_d = buf_instr;
                        buf_unload = 1'b1;
                        state_d    = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    // Request is a decode of the state register, held low during reset
    assign imem_req  = (state_q == S_REQ) && reset;
    assign imem_addr = pc_q;

    assign if_valid  = valid_q;
    assign if_pc     = if_pc_q;
    assign if_instr  = if_instr_q;
    assign if_opcode = if_instr_q[OPC_MSB:OPC_LSB];
    assign if_rd     = if_instr_q[RD_MSB:RD_LSB];
    assign if_rs     = if_instr_q[RS_MSB:RS_LSB];
    assign if_fn     = if_instr_q[FN_MSB:FN_LSB];

`ifdef FD_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    // Saturating count of stalled presentation cycles, cleared by redirect
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (redirect) begin
            stall_cnt_q <= '0;
        end else if (valid_q && stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
